// File: rtl/fibonacci_index_decoder_if.sv
// Request/response channel for the Fibonacci index decoder.
//   in_valid/in_ready/in_value   : value to decode (master -> decoder)
//   out_valid/out_ready          : result handshake (decoder -> master)
//   out_is_fib/out_index         : result payload
//   busy                         : decoder is not idle
// The master modport is the requester's view; the slave modport is the decoder's.
interface fibonacci_index_decoder_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_fib;
  logic [IDX_W-1:0] out_index;
  logic             busy;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_is_fib, out_index, busy
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_is_fib, out_index, busy
  );
endinterface

// File: rtl/fibonacci_index_decoder.sv
// Fibonacci index decoder.
// Accepts a WIDTH-bit value, then walks F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2)
// one term per clock until the current term reaches or passes the value.
// Reports whether the value is a Fibonacci number and the index of the match
// (or of the first term greater than the value).
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset; discards any search in flight
//   bus  : slave side of fibonacci_index_decoder_if (request, result, busy)
module fibonacci_index_decoder #(
  parameter int    WIDTH     = 32,
  parameter int    IDX_W     = 7,
  parameter string DUMP_NAME = "fibonacci_index_decoder_dump"
) (
  input  logic                            clk,
  input  logic                            rst,
  fibonacci_index_decoder_if.slave        bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state;
  // Two extra bits keep a+b from wrapping: the first term above 2^WIDTH-1 is
  // below 2^(WIDTH+1), and the term after it is still below 2^(WIDTH+2).
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] b;
  logic [IDX_W-1:0] k;
  logic [WIDTH-1:0] target;
  logic             is_fib_q;
  logic [IDX_W-1:0] index_q;
  logic [WIDTH+1:0] target_ext;

  assign target_ext = {2'b00, target};

  // Handshake flags depend on registered state only, so there is no
  // combinational path from in_valid or out_ready to any output.
  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.out_is_fib = is_fib_q;
  assign bus.out_index  = index_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others (a<=b and b<=a+b rely on it).
  // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
  // takes effect without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= {{(WIDTH+1){1'b0}}, 1'b1};
      k        <= '0;
      target   <= '0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            target <= bus.in_value;
            a      <= '0;
            b      <= {{(WIDTH+1){1'b0}}, 1'b1};
            k      <= '0;
            state  <= SEARCH;
          end
        end

        SEARCH: begin
          // Testing equality before advancing makes value 1 resolve to
          // index 1 rather than the duplicate term at index 2.
          if (a == target_ext) begin
            is_fib_q <= 1'b1;
            index_q  <= k;
            state    <= RESP;
          end else if (a > target_ext) begin
            is_fib_q <= 1'b0;
            index_q  <= k;
            state    <= RESP;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + 1'b1;
          end
        end

        RESP: begin
          if (bus.out_ready) begin
            is_fib_q <= 1'b0;
            index_q  <= '0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
// Self-checking bench for fibonacci_index_decoder (WIDTH=32, IDX_W=7).
// Expected results are queued when a request is accepted and popped when the
// decoder presents a result.
module tb_fibonacci_index_decoder;

  localparam int WIDTH = 32;
  localparam int IDX_W = 7;

  typedef struct packed {
    logic             is_fib;
    logic [IDX_W-1:0] index;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  fibonacci_index_decoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  fibonacci_index_decoder #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one popped scoreboard entry against the presented result.
  task automatic check_result(input string nm);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: result with empty scoreboard (is_fib=%b index=%0d)",
               nm, bus.out_is_fib, bus.out_index);
      return;
    end
    e = sb.pop_front();
    if (bus.out_is_fib !== e.is_fib || bus.out_index !== e.index) begin
      bad++;
      $display("FAIL %s: got is_fib=%b index=%0d, want is_fib=%b index=%0d",
               nm, bus.out_is_fib, bus.out_index, e.is_fib, e.index);
    end
  endtask

  // Single request with out_ready=1: checks acceptance, latency, payload and
  // the clean return to IDLE after the handshake.
  task automatic do_req(input logic [WIDTH-1:0] v, input logic ef,
                        input logic [IDX_W-1:0] ei, input string nm);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready: got=%b want=1", nm, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_value = v;
    e.is_fib = ef;
    e.index  = ei;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_value = $urandom;  // must not disturb the search in flight
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      got = bus.out_valid;
    end
    total++;
    if (!got || n != int'(ei) + 1) begin
      bad++;
      $display("FAIL %s latency: got=%0d edges (valid=%b) want=%0d", nm, n, got, int'(ei) + 1);
    end
    if (got) begin
      check_result(nm);
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.out_is_fib !== 1'b0 ||
          bus.out_index !== '0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s release: got valid=%b is_fib=%b index=%0d in_ready=%b want 0 0 0 1",
                 nm, bus.out_valid, bus.out_is_fib, bus.out_index, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_is_fib !== 1'b0 ||
        bus.out_index !== '0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: got valid=%b is_fib=%b index=%0d busy=%b want 0 0 0 0",
               bus.out_valid, bus.out_is_fib, bus.out_index, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset in_ready: got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_small();
    do_req(32'd0,   1'b1, 7'd0,  "val0");
    do_req(32'd1,   1'b1, 7'd1,  "val1");
    do_req(32'd144, 1'b1, 7'd12, "val144");
    do_req(32'd4,   1'b0, 7'd5,  "val4");
  endtask

  task automatic test_extremes();
    do_req(32'd2971215073, 1'b1, 7'd47, "f47");
    do_req(32'hFFFF_FFFF,  1'b0, 7'd48, "max");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_value  = 32'd21;
    e.is_fib = 1'b1;
    e.index  = 7'd8;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp wait: got out_valid=%b want=1", bus.out_valid);
    end
    check_result("bp21");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i == 2);
      bus.in_value = 32'd0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_is_fib !== 1'b1 ||
          bus.out_index !== 7'd8 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp hold %0d: got valid=%b is_fib=%b index=%0d in_ready=%b want 1 1 8 0",
                 i, bus.out_valid, bus.out_is_fib, bus.out_index, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp release: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    // The pulsed in_valid during RESP must not have been latched.
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL bp ignored pulse: got busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_search();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_is_fib !== 1'b0 || bus.out_index !== '0) begin
      bad++;
      $display("FAIL mid reset: got valid=%b busy=%b is_fib=%b index=%0d want 0 0 0 0",
               bus.out_valid, bus.busy, bus.out_is_fib, bus.out_index);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid reset in_ready: got=%b want=1", bus.in_ready);
    end
    do_req(32'd8, 1'b1, 7'd6, "after_rst8");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
    logic [IDX_W-1:0] idxs [8] = '{7'd0, 7'd1, 7'd1, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7};
    int received;
    received = 0;
    bus.out_ready = 1'b1;
    fork
      begin : driver
        exp_t e;
        int   w;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus.in_valid = 1'b1;
          bus.in_value = vals[i];
          w = 0;
          while (bus.in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
          end
          e.is_fib = 1'b1;
          e.index  = idxs[i];
          sb.push_back(e);
          @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (received < 8 && cyc < 500) begin
          @(negedge clk);
          cyc++;
          if (bus.out_valid && bus.out_ready) begin
            check_result("stream");
            received++;
          end
        end
      end
    join
    total++;
    if (received != 8 || sb.size() != 0) begin
      bad++;
      $display("FAIL stream count: got received=%0d leftover=%0d want 8 0", received, sb.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_small();
    test_extremes();
    test_backpressure();
    test_reset_mid_search();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
